// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared definitions for the pipeline control unit: RISC-V opcode constants,
// the NOP/bubble encoding, the stage-entry record and register-use decode helpers.
package pipe_ctrl_unit_pkg;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;

    // addi x0, x0, 0
    localparam logic [31:0] NopInst = 32'h0000_0013;

    // The PC field is sized for the widest supported XLEN; narrower
    // instances zero-extend on write and slice on read.
    localparam int unsigned PcMaxW = 64;

    typedef struct packed {
        logic [31:0]       inst;
        logic [PcMaxW-1:0] pc;
        logic              valid;
    } stage_entry_t;

    localparam stage_entry_t Bubble = '{inst: NopInst, pc: '0, valid: 1'b0};

    function automatic logic reads_rs1(input logic [6:0] opcode);
        return !(opcode == OpLui || opcode == OpAuipc || opcode == OpJal);
    endfunction

    function automatic logic reads_rs2(input logic [6:0] opcode);
        return (opcode == OpBranch || opcode == OpStore || opcode == OpOp);
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_stage_reg.sv
// pipe_stage_reg: one pipeline stage register holding {inst, pc, valid}.
// Ports:
//   clk, rst  - clock and synchronous active-high reset (reset loads a bubble)
//   en_i      - update enable; when low the stage holds
//   clr_i     - with en_i, load a bubble instead of d_i
//   d_i       - incoming stage entry
//   q_o       - registered stage entry
module pipe_stage_reg
    import pipe_ctrl_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    input  stage_entry_t d_i,
    output stage_entry_t q_o
);

    stage_entry_t entry_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= Bubble;
        end else if (en_i) begin
            entry_q <= clr_i ? Bubble : d_i;
        end
    end

    assign q_o = entry_q;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: fetch PC and post-fetch stage tracking for an in-order
// pipeline, with load-use interlock, EX-stage redirect and external stall.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   inst_i          - instruction fetched at pc_o this cycle
//   pc_o            - registered fetch PC
//   redirect_i      - taken branch/jump resolved in EX, target redirect_pc_i
//   ext_stall_i     - freezes every register
//   stage_inst_o    - per-stage instruction, stage k at [32k+31:32k]
//   stage_pc_o      - per-stage PC, stage k at [XLEN*k+XLEN-1:XLEN*k]
//   stage_valid_o   - per-stage valid
//   hazard_stall_o  - load-use stall taken this cycle (combinational)
//   flush_o         - redirect accepted this cycle (combinational)
module pipe_ctrl_unit
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     NSTAGE   = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          inst_i,
    output logic [XLEN-1:0]      pc_o,
    input  logic                 redirect_i,
    input  logic [XLEN-1:0]      redirect_pc_i,
    input  logic                 ext_stall_i,
    output logic [NSTAGE*32-1:0] stage_inst_o,
    output logic [NSTAGE*XLEN-1:0] stage_pc_o,
    output logic [NSTAGE-1:0]    stage_valid_o,
    output logic                 hazard_stall_o,
    output logic                 flush_o
);

    logic [XLEN-1:0] pc_q, pc_d;
    stage_entry_t    stage_q [NSTAGE];
    stage_entry_t    stage_d [NSTAGE];
    stage_entry_t    fetch_entry;
    logic [NSTAGE-1:0] stage_en, stage_clr;
    logic            hazard;

    // Load-use detection between EX (stage 1) and ID (stage 0).
    always_comb begin
        logic [31:0] id_inst, ex_inst;
        logic [4:0]  ex_rd;
        id_inst = stage_q[0].inst;
        ex_inst = stage_q[1].inst;
        ex_rd   = ex_inst[11:7];
        hazard  = stage_q[1].valid && (ex_inst[6:0] == OpLoad) && (ex_rd != 5'd0) &&
                  stage_q[0].valid &&
                  ((reads_rs1(id_inst[6:0]) && (id_inst[19:15] == ex_rd)) ||
                   (reads_rs2(id_inst[6:0]) && (id_inst[24:20] == ex_rd)));
    end

    // Priority: external stall, then redirect, then load-use.
    always_comb begin
        pc_d      = pc_q;
        stage_en  = '0;
        stage_clr = '0;
        if (!ext_stall_i) begin
            stage_en = '1;
            if (redirect_i) begin
                pc_d           = {redirect_pc_i[XLEN-1:2], 2'b00};
                stage_clr[1:0] = 2'b11;
            end else if (hazard) begin
                // ID and PC hold; a bubble goes into EX.
                stage_en[0]  = 1'b0;
                stage_clr[1] = 1'b1;
            end else begin
                pc_d = pc_q + XLEN'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_comb begin
        fetch_entry                = '0;
        fetch_entry.inst           = inst_i;
        fetch_entry.pc[XLEN-1:0]   = pc_q;
        fetch_entry.valid          = 1'b1;
    end

    logic [NSTAGE-1:0] unused_pc_hi;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign stage_d[k] = fetch_entry;
        end else begin : g_rest
            assign stage_d[k] = stage_q[k-1];
        end

        pipe_stage_reg u_stage_reg (
            .clk   (clk),
            .rst   (rst),
            .en_i  (stage_en[k]),
            .clr_i (stage_clr[k]),
            .d_i   (stage_d[k]),
            .q_o   (stage_q[k])
        );

        assign stage_inst_o[32*k +: 32]    = stage_q[k].inst;
        assign stage_pc_o[XLEN*k +: XLEN]  = stage_q[k].pc[XLEN-1:0];
        assign stage_valid_o[k]            = stage_q[k].valid;
        // PC bits above XLEN are always zero.
        assign unused_pc_hi[k]             = |(stage_q[k].pc >> XLEN);
    end

    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc_i[1:0];

    assign pc_o           = pc_q;
    assign hazard_stall_o = hazard & ~redirect_i & ~ext_stall_i;
    assign flush_o        = redirect_i & ~ext_stall_i;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
module tb_pipe_ctrl_unit;

    localparam int XLEN   = 32;
    localparam int NSTAGE = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [31:0]            inst_i;
    logic                   redirect_i;
    logic [XLEN-1:0]        redirect_pc_i;
    logic                   ext_stall_i;
    logic [XLEN-1:0]        pc_o, w_pc_o;
    logic [NSTAGE*32-1:0]   stage_inst_o, w_stage_inst_o;
    logic [NSTAGE*XLEN-1:0] stage_pc_o, w_stage_pc_o;
    logic [NSTAGE-1:0]      stage_valid_o, w_stage_valid_o;
    logic                   hazard_stall_o, w_hazard_stall_o;
    logic                   flush_o, w_flush_o;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.XLEN(XLEN), .NSTAGE(NSTAGE), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_i         (inst_i),
        .pc_o           (pc_o),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .ext_stall_i    (ext_stall_i),
        .stage_inst_o   (stage_inst_o),
        .stage_pc_o     (stage_pc_o),
        .stage_valid_o  (stage_valid_o),
        .hazard_stall_o (hazard_stall_o),
        .flush_o        (flush_o)
    );

    // Second instance only for the PC wrap-around check.
    pipe_ctrl_unit #(.XLEN(XLEN), .NSTAGE(NSTAGE), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk            (clk),
        .rst            (rst),
        .inst_i         (inst_i),
        .pc_o           (w_pc_o),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .ext_stall_i    (ext_stall_i),
        .stage_inst_o   (w_stage_inst_o),
        .stage_pc_o     (w_stage_pc_o),
        .stage_valid_o  (w_stage_valid_o),
        .hazard_stall_o (w_hazard_stall_o),
        .flush_o        (w_flush_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model: pipeline as a queue, index 0 = ID ----------------
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        valid;
    } ent_t;

    ent_t        pipe[$];
    logic [31:0] mpc;

    function automatic ent_t bub();
        ent_t e;
        e.inst = 32'h0000_0013;
        e.pc = 32'h0;
        e.valid = 1'b0;
        return e;
    endfunction

    function automatic bit uses_rs1(input logic [6:0] op);
        return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    endfunction

    function automatic bit uses_rs2(input logic [6:0] op);
        return (op == 7'b1100011 || op == 7'b0100011 || op == 7'b0110011);
    endfunction

    function automatic bit m_load_use();
        logic [31:0] c, p;
        logic [4:0]  rd;
        c  = pipe[0].inst;
        p  = pipe[1].inst;
        rd = p[11:7];
        if (!pipe[1].valid || !pipe[0].valid) return 0;
        if (p[6:0] != 7'b0000011 || rd == 0) return 0;
        return (uses_rs1(c[6:0]) && c[19:15] == rd) || (uses_rs2(c[6:0]) && c[24:20] == rd);
    endfunction

    task automatic m_reset();
        pipe.delete();
        for (int k = 0; k < NSTAGE; k++) pipe.push_back(bub());
        mpc = 32'h0;
    endtask

    task automatic m_step();
        ent_t e;
        if (ext_stall_i) return;
        if (redirect_i) begin
            void'(pipe.pop_front());
            pipe.push_front(bub());
            pipe.push_front(bub());
            void'(pipe.pop_back());
            mpc = redirect_pc_i & ~32'h3;
        end else if (m_load_use()) begin
            pipe.insert(1, bub());
            void'(pipe.pop_back());
        end else begin
            e.inst = inst_i;
            e.pc = mpc;
            e.valid = 1'b1;
            pipe.push_front(e);
            void'(pipe.pop_back());
            mpc = mpc + 32'd4;
        end
    endtask

    // Drive inputs for one cycle and compare every output against the model.
    task automatic drive(input logic [31:0] inst, input bit red, input logic [31:0] rpc,
                         input bit stall);
        logic [NSTAGE*32-1:0]   e_inst;
        logic [NSTAGE*XLEN-1:0] e_pc;
        logic [NSTAGE-1:0]      e_v;
        inst_i = inst;
        redirect_i = red;
        redirect_pc_i = rpc;
        ext_stall_i = stall;
        #1;
        for (int k = 0; k < NSTAGE; k++) begin
            e_inst[32*k +: 32] = pipe[k].inst;
            e_pc[XLEN*k +: XLEN] = pipe[k].pc;
            e_v[k] = pipe[k].valid;
        end
        chk("model_pc", pc_o, mpc);
        chk("model_inst", stage_inst_o, e_inst);
        chk("model_spc", stage_pc_o, e_pc);
        chk("model_valid", stage_valid_o, e_v);
        chk("model_hazard", hazard_stall_o, m_load_use() && !red && !stall);
        chk("model_flush", flush_o, red && !stall);
    endtask

    task automatic clock();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ext_stall_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0400;
        inst_i = 32'h0000_A283;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ext_stall_i = 1'b0;
        redirect_i = 1'b0;
        m_reset();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [31:0] inst;
        bit          red;
        logic [31:0] rpc;
        bit          stall;
        logic [31:0] e_pc;
        logic [3:0]  e_v;
        bit          e_hz;
        bit          e_fl;
    } vec_t;

    localparam logic [31:0] LW5   = 32'h0000_A283;
    localparam logic [31:0] ADD6  = 32'h0072_8333;
    localparam logic [31:0] ADDI  = 32'h0010_0093;
    localparam logic [31:0] LW0   = 32'h0000_A003;
    localparam logic [31:0] ADDX0 = 32'h0000_0333;

    vec_t tbl[17];

    initial begin
        logic [31:0] rinst;
        logic [6:0]  ops[8];
        tbl[0]  = '{LW5,   0, 32'h0,   0, 32'h000, 4'b0000, 0, 0};
        tbl[1]  = '{ADD6,  0, 32'h0,   0, 32'h004, 4'b0001, 0, 0};
        tbl[2]  = '{ADDI,  0, 32'h0,   0, 32'h008, 4'b0011, 1, 0};
        tbl[3]  = '{ADDI,  0, 32'h0,   0, 32'h008, 4'b0101, 0, 0};
        tbl[4]  = '{ADDI,  0, 32'h0,   0, 32'h00C, 4'b1011, 0, 0};
        tbl[5]  = '{LW0,   0, 32'h0,   0, 32'h010, 4'b0111, 0, 0};
        tbl[6]  = '{ADDX0, 0, 32'h0,   0, 32'h014, 4'b1111, 0, 0};
        tbl[7]  = '{ADDI,  0, 32'h0,   0, 32'h018, 4'b1111, 0, 0};
        tbl[8]  = '{LW5,   0, 32'h0,   0, 32'h01C, 4'b1111, 0, 0};
        tbl[9]  = '{ADD6,  0, 32'h0,   0, 32'h020, 4'b1111, 0, 0};
        tbl[10] = '{ADDI,  1, 32'h103, 0, 32'h024, 4'b1111, 0, 1};
        tbl[11] = '{ADDI,  1, 32'h203, 1, 32'h100, 4'b1100, 0, 0};
        tbl[12] = '{ADDI,  1, 32'h203, 1, 32'h100, 4'b1100, 0, 0};
        tbl[13] = '{ADDI,  1, 32'h203, 1, 32'h100, 4'b1100, 0, 0};
        tbl[14] = '{ADDI,  1, 32'h203, 0, 32'h100, 4'b1100, 0, 1};
        tbl[15] = '{ADDI,  0, 32'h0,   0, 32'h200, 4'b1000, 0, 0};
        tbl[16] = '{ADDI,  0, 32'h0,   0, 32'h204, 4'b0001, 0, 0};

        ops = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b0010011};

        // Reset, with stall and redirect asserted to show reset wins.
        do_reset();
        chk("reset_pc", pc_o, 32'h0);
        chk("reset_valid", stage_valid_o, 4'b0000);
        chk("reset_inst", stage_inst_o, {4{32'h0000_0013}});
        chk("reset_spc", stage_pc_o, 128'h0);
        chk("wrap_reset_pc", w_pc_o, 32'hFFFF_FFFC);

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].inst, tbl[i].red, tbl[i].rpc, tbl[i].stall);
            chk($sformatf("tbl%0d_pc", i), pc_o, tbl[i].e_pc);
            chk($sformatf("tbl%0d_valid", i), stage_valid_o, tbl[i].e_v);
            chk($sformatf("tbl%0d_hazard", i), hazard_stall_o, tbl[i].e_hz);
            chk($sformatf("tbl%0d_flush", i), flush_o, tbl[i].e_fl);
            if (i == 1) chk("wrap_pc", w_pc_o, 32'h0);
            if (i == 11) chk("redirect_s2_pc", stage_pc_o[64 +: 32], 32'h01C);
            clock();
        end

        // Straight-line ADDI stream: fetch at pc 0x8 reaches stage 3 four cycles later.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(ADDI, 0, 32'h0, 0);
            clock();
        end
        drive(ADDI, 0, 32'h0, 0);
        chk("straight_s3_pc", stage_pc_o[96 +: 32], 32'h8);
        chk("straight_s3_valid", stage_valid_o[3], 1'b1);
        chk("straight_s3_inst", stage_inst_o[96 +: 32], ADDI);
        clock();

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rinst = $urandom;
            rinst[6:0] = ops[$urandom_range(0, 7)];
            rinst[11:7] = 5'($urandom_range(0, 3));
            rinst[19:15] = 5'($urandom_range(0, 3));
            rinst[24:20] = 5'($urandom_range(0, 3));
            drive(rinst, ($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 7) == 0));
            clock();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 Parameter XLEN, 32, width of PC and datapath addresses.
REQ-002 Parameter NSTAGE, 4, number of post-fetch stages (index 0=ID, 1=EX, 2..NSTAGE-1 = MEM, WB, ...); legal range 3..8.
REQ-003 Parameter RESET_PC, 0, fetch PC loaded on reset.
REQ-004 One clock; reset is synchronous and active-high: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-005 inst_i  in  32  instruction fetched at pc_o this cycle.
REQ-006 pc_o  out  XLEN  current fetch PC (registered).
REQ-007 redirect_i  in  1  taken branch/jump resolved in EX; redirect_pc_i  in  XLEN  target.
REQ-008 ext_stall_i  in  1  memory stall; freezes the whole pipeline.
REQ-009 stage_inst_o  out  NSTAGE*32  per-stage instruction, stage k at bits [32k+31:32k].
REQ-010 stage_pc_o  out  NSTAGE*XLEN  per-stage PC; stage_valid_o  out  NSTAGE  per-stage valid.
REQ-011 hazard_stall_o  out  1  load-use stall this cycle; flush_o  out  1  redirect accepted this cycle (both combinational).

Function
REQ-012 Normal advance (no stall, no redirect): stage[0] <= {inst_i, pc_o, valid=1}; stage[k] <= stage[k-1]; pc_o <= pc_o+4 modulo 2^XLEN.
REQ-013 Bubble = inst 0x00000013 (NOP), pc 0, valid 0.
REQ-014 Load-use hazard when stage[1] valid, opcode 0000011, rd!=0, stage[0] valid, and (stage[0] reads rs1 and rs1==rd, or stage[0] reads rs2 and rs2==rd).
REQ-015 rs1 read by every opcode except LUI (0110111), AUIPC (0010111), JAL (1101111); rs2 read only by BRANCH (1100011), STORE (0100011), OP (0110011).
REQ-016 On hazard: pc_o and stage[0] hold, stage[1] <= bubble, stages 2.. advance; exactly one stall cycle per load-use pair.
REQ-017 On redirect: pc_o <= {redirect_pc_i[XLEN-1:2], 2'b00}; stage[0] and stage[1] <= bubble; stages 2.. advance (branch itself proceeds to stage 2).
REQ-018 Priority: ext_stall_i > redirect_i > hazard; redirect coincident with hazard discards the hazard.
REQ-019 ext_stall_i=1 holds every register; redirect_i ignored that cycle (source holds it until accepted).
REQ-020 hazard_stall_o = hazard & ~redirect_i & ~ext_stall_i; flush_o = redirect_i & ~ext_stall_i.
REQ-021 Invalid stages never trigger hazards and never alter pc_o.

Reset
REQ-022 On rst=1 at a clock edge: pc_o=RESET_PC, all stages = bubble, stage_valid_o=0; rst overrides ext_stall_i and redirect_i.
REQ-023 First valid ID stage appears one cycle after rst deasserts, with pc = RESET_PC.

Structure
REQ-024 Shared package holds opcode constants (LOAD, STORE, BRANCH, OP, LUI, AUIPC, JAL), NOP encoding, and the stage-entry struct {inst, pc, valid}.
REQ-025 One sub-module pipe_stage_reg (enable, clear-to-bubble) instantiated NSTAGE times via generate; hazard/priority logic stays in the top.

Verification
REQ-026 Reset: rst high 2 cycles -> pc_o=0x0, stage_valid_o=0, all stage_inst=0x00000013; after release pc_o steps 0x0,0x4,0x8.
REQ-027 Straight line: feed ADDI stream, NSTAGE=4 -> instruction fetched at pc 0x8 appears in stage 3 with valid=1 exactly 4 cycles after fetch.
REQ-028 Load-use: lw x5,0(x1) (0x0000A283) then add x6,x5,x7 (0x00728333) -> hazard_stall_o=1 one cycle, pc_o holds, stage[1] bubble, add in EX one cycle late; same with lw x0 -> no stall.
REQ-029 Redirect: branch at pc 0x10 in EX, redirect_i=1, redirect_pc_i=0x103 -> next cycle pc_o=0x100, stage_valid_o[1:0]=0, stage[2] pc=0x10 valid.
REQ-030 Redirect coincident with load-use -> flush_o=1, hazard_stall_o=0; ext_stall_i high 3 cycles with redirect_i=1 -> all outputs frozen, flush_o=0, redirect taken on first cycle after release.
REQ-031 Wrap: RESET_PC=0xFFFFFFFC -> pc_o 0xFFFFFFFC then 0x00000000.
